banco_salidas: RTL and testbench
================================

Name: banco_salidas

Overview:
- Output-port bank: the write-side counterpart to the processor's four 8-bit input ports.
- The processor's output-register write strobes push data bytes into four independent per-port FIFOs.
- Each port drains to an external consumer over a valid/ready handshake.
- Per-port full flags return to the control unit, so programs can poll them before writing.

Parameters:
- DW, 8, data width of every port
- DEPTH, 4, entries per port FIFO; power of two, ≥2

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- dato  in  DW  byte from the datapath, written to the selected port(s)
- we_s_r  in  4  write strobes; bit0..3 = ports A..D
- datos_outA..datos_outD  out  DW each  head-of-FIFO data per port
- valid_out  out  4  port holds data (bit per port)
- ready_out  in  4  consumer accepts head this cycle (bit per port)
- lleno  out  4  port FIFO full
- ovf  out  4  write dropped on full port
- clr_ovf  in  4  clear ovf bit (STICKY_OVF_EN only)

Behaviour:
- Reset (synchronous, active-high):
  - All pointers and counts clear.
  - valid_out=0, lleno=0, ovf=0, datos_out*=0.
  - Reset mid-transfer discards all contents; a push or pop in the reset cycle is ignored.
- Per port x, each cycle:
  - pop = valid_out[x] & ready_out[x]
  - push = we_s_r[x] & (!lleno[x] | pop)
- Push and pop:
  - Push writes dato at the write pointer; pop advances the read pointer.
  - Both pointers wrap modulo DEPTH.
  - Count is $clog2(DEPTH)+1 bits: +1 on push-only, −1 on pop-only, unchanged on both.
- Full with a simultaneous pop: the push is accepted and count stays at DEPTH.
- Empty with a write: the data appears on datos_outx with valid_out[x]=1 on the next cycle. There is no same-cycle fall-through, so latency is 1 cycle.
- Outputs:
  - valid_out[x] = (count≠0).
  - lleno[x] = (count==DEPTH).
  - Both are derived from registered count.
  - datos_outx = mem[rd_ptr]. When the port is empty, datos_outx holds the last popped value, or 0 after reset.
- Multiple we_s_r bits set: the same dato is pushed to every selected port independently. One-hot is not required.
- Drop rule: we_s_r[x] & lleno[x] & !pop drops the byte and sets ovf[x] for exactly one cycle (pulse).
- Consumer side:
  - ready_out is ignored when valid_out=0.
  - Data and valid hold steady until popped.
- Ports never interact.

Optional Feature:
- Macro: STICKY_OVF_EN
- Defined:
  - ovf[x] sets on a drop and stays set until clr_ovf[x]=1.
  - Drop and clear in the same cycle leaves ovf set (set wins).
- Undefined:
  - ovf is the one-cycle pulse described above.
  - The clr_ovf port is still present but ignored.

Decomposition:
- Package banco_salidas_pkg: DW default, DEPTH default, port index constants (PUERTO_A=0..PUERTO_D=3).
- Sub-module fifo_salida: one port FIFO containing memory, pointers, count, full/valid and drop/ovf logic.
  - Instantiated 4 times via generate.
  - Top level only fans out dato/we_s_r/ready_out and packs the outputs.

Test Plan:
1. Reset, then we_s_r=0001 with dato=8'h5A, ready_out=0 → next cycle valid_out=0001, datos_outA=5A. Other ports stay invalid with data 0.
2. Port B: write 11,22,33,44 on consecutive cycles, ready=0 → lleno[1]=1 after the 4th write. A 5th write of 55 → ovf[1] pulses for 1 cycle. Draining then yields 11,22,33,44 with no 55.
3. Port C full, then same cycle we_s_r[2]=1 with dato=99 and ready_out[2]=1 → head popped, 99 accepted, lleno stays 1, ovf=0. The last drained byte is 99.
4. we_s_r=1111 with dato=8'hA7 → all four ports valid with A7 next cycle. Pop port D only → only valid_out[3] falls, and datos_outD holds A7.
5. Port A half-full (2 entries) with a continuous push/pop stream for 10 cycles → count stays 2, order is preserved, pointers wrap correctly.
6. STICKY_OVF_EN defined:
   - overflow port A → ovf[0] stays 1 for 5 cycles
   - clr_ovf[0]=1 → 0 next cycle
   - drop and clr in the same cycle → ovf stays 1
   - reset mid-fill → all outputs 0 the next cycle.

Source files
------------

// File: rtl/banco_salidas_pkg.sv
// Shared constants for the output-port bank: default widths/depths and port indices.
package banco_salidas_pkg;
  localparam int DW_DEF      = 8;
  localparam int DEPTH_DEF   = 4;
  localparam int NUM_PUERTOS = 4;
  localparam int PUERTO_A    = 0;
  localparam int PUERTO_B    = 1;
  localparam int PUERTO_C    = 2;
  localparam int PUERTO_D    = 3;
endpackage

// File: rtl/banco_salidas_if.sv
// Bus between the datapath/consumers (master) and the output-port bank (slave).
interface banco_salidas_if #(parameter int DW = 8);
  logic [DW-1:0] dato;
  logic [3:0]    we_s_r;
  logic [3:0]    clr_ovf;
  logic [3:0]    ready_out;
  logic [DW-1:0] datos_outA;
  logic [DW-1:0] datos_outB;
  logic [DW-1:0] datos_outC;
  logic [DW-1:0] datos_outD;
  logic [3:0]    valid_out;
  logic [3:0]    lleno;
  logic [3:0]    ovf;

  modport master (
    output dato, we_s_r, clr_ovf, ready_out,
    input  datos_outA, datos_outB, datos_outC, datos_outD, valid_out, lleno, ovf
  );

  modport slave (
    input  dato, we_s_r, clr_ovf, ready_out,
    output datos_outA, datos_outB, datos_outC, datos_outD, valid_out, lleno, ovf
  );
endinterface

// File: rtl/banco_salidas_fifo_salida.sv
// One output-port FIFO: storage, pointers, occupancy, full/valid and overflow flag.
// STICKY_OVF_EN makes ovf hold until clr_ovf; otherwise ovf is a one-cycle drop pulse.
module fifo_salida
  import banco_salidas_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] dato,
  input  logic          we,
  input  logic          ready,
  input  logic          clr_ovf,
  output logic [DW-1:0] datos_out,
  output logic          valid,
  output logic          lleno,
  output logic          ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [DW-1:0] last_q;
  logic          pop, push, drop;

  assign valid = (count != '0);
  assign lleno = (count == CW'(DEPTH));
  assign pop   = valid & ready;
  assign push  = we & (~lleno | pop);
  assign drop  = we & lleno & ~pop;

  // An empty port shows the last byte it handed out rather than stale storage.
  assign datos_out = valid ? mem[rd_ptr] : last_q;

  always_ff @(posedge clk) begin
    if (push && !reset)
      mem[wr_ptr] <= dato;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_q <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef STICKY_OVF_EN
  always_ff @(posedge clk) begin
    if (reset)
      ovf <= 1'b0;
    else
      ovf <= drop | (ovf & ~clr_ovf);
  end
`else
  logic unused_clr_ovf;
  assign unused_clr_ovf = clr_ovf;

  always_ff @(posedge clk) begin
    if (reset)
      ovf <= 1'b0;
    else
      ovf <= drop;
  end
`endif
endmodule

// File: rtl/banco_salidas.sv
// Output-port bank: four independent port FIFOs fed by the datapath write strobes.
// Build option STICKY_OVF_EN selects sticky overflow flags in every port.
module banco_salidas
  import banco_salidas_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic clk,
  input  logic reset,
  banco_salidas_if.slave bus
);
  logic [DW-1:0]          datos [NUM_PUERTOS];
  logic [NUM_PUERTOS-1:0] valid_v, lleno_v, ovf_v;

  for (genvar i = 0; i < NUM_PUERTOS; i++) begin : g_puerto
    fifo_salida #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .dato      (bus.dato),
      .we        (bus.we_s_r[i]),
      .ready     (bus.ready_out[i]),
      .clr_ovf   (bus.clr_ovf[i]),
      .datos_out (datos[i]),
      .valid     (valid_v[i]),
      .lleno     (lleno_v[i]),
      .ovf       (ovf_v[i])
    );
  end

  assign bus.datos_outA = datos[PUERTO_A];
  assign bus.datos_outB = datos[PUERTO_B];
  assign bus.datos_outC = datos[PUERTO_C];
  assign bus.datos_outD = datos[PUERTO_D];
  assign bus.valid_out  = valid_v;
  assign bus.lleno      = lleno_v;
  assign bus.ovf        = ovf_v;
endmodule

// File: tb/tb_banco_salidas.sv
// Bench for banco_salidas: queue-based port model checked every cycle, directed scenarios, random traffic.
module tb_banco_salidas;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  banco_salidas_if #(.DW(8)) bus ();
  banco_salidas #(.DW(8), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  logic [7:0] q [4][$];
  logic [7:0] last_pop [4];
  logic [3:0] m_ovf;
  bit         model_ok = 0;
  logic [7:0] dut_d [4];

  assign dut_d[0] = bus.datos_outA;
  assign dut_d[1] = bus.datos_outB;
  assign dut_d[2] = bus.datos_outC;
  assign dut_d[3] = bus.datos_outD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: per-port queue, decisions based on the occupancy before the edge.
  always @(posedge clk) begin
    if (reset) begin
      for (int x = 0; x < 4; x++) begin
        q[x].delete();
        last_pop[x] = 8'h00;
      end
      m_ovf    = 4'b0;
      model_ok = 1;
    end else begin
      for (int x = 0; x < 4; x++) begin
        bit v, full, pop, push, drop;
        v    = q[x].size() != 0;
        full = q[x].size() == DEPTH;
        pop  = v && bus.ready_out[x];
        push = bus.we_s_r[x] && (!full || pop);
        drop = bus.we_s_r[x] && full && !pop;
        if (pop)  last_pop[x] = q[x].pop_front();
        if (push) q[x].push_back(bus.dato);
`ifdef STICKY_OVF_EN
        m_ovf[x] = drop || (m_ovf[x] && !bus.clr_ovf[x]);
`else
        m_ovf[x] = drop;
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      for (int x = 0; x < 4; x++) begin
        chk($sformatf("valid[%0d]", x), 32'(bus.valid_out[x]), 32'(q[x].size() != 0));
        chk($sformatf("lleno[%0d]", x), 32'(bus.lleno[x]), 32'(q[x].size() == DEPTH));
        chk($sformatf("ovf[%0d]", x), 32'(bus.ovf[x]), 32'(m_ovf[x]));
        chk($sformatf("datos[%0d]", x), 32'(dut_d[x]),
            32'((q[x].size() != 0) ? q[x][0] : last_pop[x]));
      end
    end
  end

  task automatic cyc(input logic [3:0] we, input logic [7:0] d, input logic [3:0] rdy,
                     input logic [3:0] clr = 4'b0, input logic rst = 1'b0);
    bus.we_s_r    = we;
    bus.dato      = d;
    bus.ready_out = rdy;
    bus.clr_ovf   = clr;
    reset         = rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_c [4];
    bus.we_s_r = 4'b0; bus.dato = 8'h0; bus.ready_out = 4'b0; bus.clr_ovf = 4'b0;
    cyc(4'b0, 8'h0, 4'b0, 4'b0, 1'b1);
    cyc(4'b0, 8'h0, 4'b0, 4'b0, 1'b1);
    chk("reset_valid", 32'(bus.valid_out), 32'h0);
    chk("reset_lleno", 32'(bus.lleno), 32'h0);

    // 1: single write to A, one cycle latency
    cyc(4'b0001, 8'h5A, 4'b0);
    chk("t1_valid", 32'(bus.valid_out), 32'h1);
    chk("t1_datA", 32'(bus.datos_outA), 32'h5A);
    chk("t1_datB", 32'(bus.datos_outB), 32'h0);
    cyc(4'b0, 8'h0, 4'b0001);
    chk("t1_drained", 32'(bus.valid_out), 32'h0);
    chk("t1_hold", 32'(bus.datos_outA), 32'h5A);

    // 2: fill B, drop 55, drain in order
    cyc(4'b0010, 8'h11, 4'b0);
    cyc(4'b0010, 8'h22, 4'b0);
    cyc(4'b0010, 8'h33, 4'b0);
    cyc(4'b0010, 8'h44, 4'b0);
    chk("t2_lleno", 32'(bus.lleno), 32'h2);
    cyc(4'b0010, 8'h55, 4'b0);
    chk("t2_ovf", 32'(bus.ovf), 32'h2);
    cyc(4'b0, 8'h0, 4'b0);
`ifndef STICKY_OVF_EN
    chk("t2_ovf_pulse", 32'(bus.ovf), 32'h0);
`else
    chk("t2_ovf_sticky", 32'(bus.ovf), 32'h2);
    cyc(4'b0, 8'h0, 4'b0, 4'b0010);
`endif
    exp_c = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_head%0d", i), 32'(bus.datos_outB), 32'(exp_c[i]));
      cyc(4'b0, 8'h0, 4'b0010);
    end
    chk("t2_empty", 32'(bus.valid_out), 32'h0);
    chk("t2_hold", 32'(bus.datos_outB), 32'h44);

    // 3: full port C with simultaneous pop and push
    for (int i = 0; i < 4; i++) cyc(4'b0100, 8'(8'hC1 + i), 4'b0);
    cyc(4'b0100, 8'h99, 4'b0100);
    chk("t3_lleno", 32'(bus.lleno[2]), 32'h1);
    chk("t3_ovf", 32'(bus.ovf[2]), 32'h0);
    exp_c = '{8'hC2, 8'hC3, 8'hC4, 8'h99};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_head%0d", i), 32'(bus.datos_outC), 32'(exp_c[i]));
      cyc(4'b0, 8'h0, 4'b0100);
    end
    chk("t3_last", 32'(bus.datos_outC), 32'h99);

    // 4: broadcast write, pop only D
    cyc(4'b1111, 8'hA7, 4'b0);
    chk("t4_valid", 32'(bus.valid_out), 32'hF);
    chk("t4_datA", 32'(bus.datos_outA), 32'hA7);
    chk("t4_datC", 32'(bus.datos_outC), 32'hA7);
    cyc(4'b0, 8'h0, 4'b1000);
    chk("t4_popD", 32'(bus.valid_out), 32'h7);
    chk("t4_holdD", 32'(bus.datos_outD), 32'hA7);
    cyc(4'b0, 8'h0, 4'b0111);

    // 5: steady push/pop stream on A with two entries in flight
    cyc(4'b0001, 8'h10, 4'b0);
    cyc(4'b0001, 8'h11, 4'b0);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t5_head%0d", i), 32'(bus.datos_outA), 32'(8'h10 + i));
      cyc(4'b0001, 8'(8'h12 + i), 4'b0001);
      chk($sformatf("t5_lleno%0d", i), 32'(bus.lleno[0]), 32'h0);
    end
    chk("t5_tail0", 32'(bus.datos_outA), 32'h1A);
    cyc(4'b0, 8'h0, 4'b0001);
    chk("t5_tail1", 32'(bus.datos_outA), 32'h1B);
    cyc(4'b0, 8'h0, 4'b0001);
    chk("t5_empty", 32'(bus.valid_out[0]), 32'h0);

`ifdef STICKY_OVF_EN
    // 6: sticky overflow on A
    for (int i = 0; i < 4; i++) cyc(4'b0001, 8'(8'hA1 + i), 4'b0);
    cyc(4'b0001, 8'hA5, 4'b0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t6_stick%0d", i), 32'(bus.ovf[0]), 32'h1);
      cyc(4'b0, 8'h0, 4'b0);
    end
    cyc(4'b0, 8'h0, 4'b0, 4'b0001);
    chk("t6_clr", 32'(bus.ovf[0]), 32'h0);
    cyc(4'b0001, 8'hA6, 4'b0, 4'b0001);
    chk("t6_set_wins", 32'(bus.ovf[0]), 32'h1);
`else
    cyc(4'b0001, 8'hA1, 4'b0);
    cyc(4'b0011, 8'hA2, 4'b0);
`endif
    // reset mid-fill with a push and pop in the reset cycle
    cyc(4'b0011, 8'h77, 4'b0011, 4'b0, 1'b1);
    chk("rst_valid", 32'(bus.valid_out), 32'h0);
    chk("rst_lleno", 32'(bus.lleno), 32'h0);
    chk("rst_ovf", 32'(bus.ovf), 32'h0);
    chk("rst_datA", 32'(bus.datos_outA), 32'h0);
    chk("rst_datB", 32'(bus.datos_outB), 32'h0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] we, rdy, clr;
      for (int b = 0; b < 4; b++) begin
        we[b]  = ($urandom_range(0, 9) < 6);
        rdy[b] = ($urandom_range(0, 9) < 4);
        clr[b] = ($urandom_range(0, 9) < 2);
      end
      cyc(we, 8'($urandom), rdy, clr, ($urandom_range(0, 299) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
